// File: rtl/rice_core_pkg.sv
// Shared types for the rice core bus fabric.
// The source ID tags each outstanding memory request with the port that issued it.
package rice_core_pkg;

  typedef enum logic {
    RICE_BUS_SOURCE_INST,
    RICE_BUS_SOURCE_DATA
  } rice_bus_source;

  typedef enum logic {
    RICE_BUS_ARB_OPEN,
    RICE_BUS_ARB_LOCKED
  } rice_bus_arb_state;

endpackage

// File: rtl/rice_core_bus_arbiter_source_fifo.sv
// Ordered queue of grant sources for in-order response routing.
// Pointers wrap at DEPTH, so DEPTH does not have to be a power of two.
module rice_core_bus_arbiter_source_fifo
  import rice_core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_push,
  input  rice_bus_source i_push_id,
  input  logic           i_pop,
  output logic           o_full,
  output logic           o_empty,
  output rice_bus_source o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  rice_bus_source   slots_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_head  = slots_q[rd_ptr_q];
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= RICE_BUS_SOURCE_INST;
    end else if (push_ok) begin
      slots_q[wr_ptr_q] <= i_push_id;
    end
  end

endmodule

// File: rtl/rice_core_bus_arbiter.sv
// Round-robin 2:1 arbiter joining instruction fetch and load/store onto one memory port.
// A stalled grant is locked until its handshake; responses route by the queued source ID.
module rice_core_bus_arbiter
  import rice_core_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_inst_request_valid,
  output logic              o_inst_request_ready,
  input  logic [XLEN-1:0]   i_inst_address,
  output logic              o_inst_response_valid,
  input  logic              i_inst_response_ready,
  output logic [XLEN-1:0]   o_inst_response_data,
  output logic              o_inst_response_error,
  input  logic              i_data_request_valid,
  output logic              o_data_request_ready,
  input  logic [XLEN-1:0]   i_data_address,
  input  logic [XLEN-1:0]   i_data_write_data,
  input  logic              i_data_write,
  input  logic [XLEN/8-1:0] i_data_strobe,
  output logic              o_data_response_valid,
  input  logic              i_data_response_ready,
  output logic [XLEN-1:0]   o_data_response_data,
  output logic              o_data_response_error,
  output logic              o_mem_request_valid,
  input  logic              i_mem_request_ready,
  output logic [XLEN-1:0]   o_mem_address,
  output logic [XLEN-1:0]   o_mem_write_data,
  output logic              o_mem_write,
  output logic [XLEN/8-1:0] o_mem_strobe,
  input  logic              i_mem_response_valid,
  output logic              o_mem_response_ready,
  input  logic [XLEN-1:0]   i_mem_response_data,
  input  logic              i_mem_response_error
);

  rice_bus_arb_state state_q, state_d;
  rice_bus_source    held_grant_q, last_grant_q, grant, head;
  logic              grant_active, src_valid, full, empty;
  logic              req_handshake, rsp_handshake;

  assign req_handshake = o_mem_request_valid && i_mem_request_ready;
  assign rsp_handshake = i_mem_response_valid && o_mem_response_ready;

  // last_grant resets to DATA so INST wins the first tie after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= RICE_BUS_ARB_OPEN;
      held_grant_q <= RICE_BUS_SOURCE_INST;
      last_grant_q <= RICE_BUS_SOURCE_DATA;
    end else begin
      state_q      <= state_d;
      held_grant_q <= grant;
      if (req_handshake) last_grant_q <= grant;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RICE_BUS_ARB_OPEN:   if (o_mem_request_valid && !i_mem_request_ready) state_d = RICE_BUS_ARB_LOCKED;
      RICE_BUS_ARB_LOCKED: if (req_handshake) state_d = RICE_BUS_ARB_OPEN;
      default:             state_d = RICE_BUS_ARB_OPEN;
    endcase
  end

  always_comb begin
    grant        = RICE_BUS_SOURCE_INST;
    grant_active = 1'b0;
    if (state_q == RICE_BUS_ARB_LOCKED) begin
      grant        = held_grant_q;
      grant_active = 1'b1;
    end else if (!full) begin
      grant_active = i_inst_request_valid || i_data_request_valid;
      if (i_inst_request_valid && i_data_request_valid)
        grant = (last_grant_q == RICE_BUS_SOURCE_DATA) ? RICE_BUS_SOURCE_INST : RICE_BUS_SOURCE_DATA;
      else if (i_data_request_valid)
        grant = RICE_BUS_SOURCE_DATA;
    end
    src_valid = (grant == RICE_BUS_SOURCE_DATA) ? i_data_request_valid : i_inst_request_valid;
    o_mem_request_valid  = grant_active && src_valid && !full;
    o_inst_request_ready = grant_active && (grant == RICE_BUS_SOURCE_INST) && i_mem_request_ready && !full;
    o_data_request_ready = grant_active && (grant == RICE_BUS_SOURCE_DATA) && i_mem_request_ready && !full;
    if (grant == RICE_BUS_SOURCE_DATA) begin
      o_mem_address    = i_data_address;
      o_mem_write_data = i_data_write_data;
      o_mem_write      = i_data_write;
      o_mem_strobe     = i_data_strobe;
    end else begin
      o_mem_address    = i_inst_address;
      o_mem_write_data = '0;
      o_mem_write      = 1'b0;
      o_mem_strobe     = '0;
    end
  end

  rice_core_bus_arbiter_source_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_source_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_push   (req_handshake),
    .i_push_id(grant),
    .i_pop    (rsp_handshake),
    .o_full   (full),
    .o_empty  (empty),
    .o_head   (head)
  );

  assign o_inst_response_valid = i_mem_response_valid && !empty && (head == RICE_BUS_SOURCE_INST);
  assign o_data_response_valid = i_mem_response_valid && !empty && (head == RICE_BUS_SOURCE_DATA);
  assign o_mem_response_ready  = !empty &&
                                 ((head == RICE_BUS_SOURCE_INST) ? i_inst_response_ready : i_data_response_ready);
  assign o_inst_response_data  = i_mem_response_data;
  assign o_inst_response_error = i_mem_response_error;
  assign o_data_response_data  = i_mem_response_data;
  assign o_data_response_error = i_mem_response_error;

  // A response with nothing outstanding is a memory-side protocol error.
  response_without_request: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_mem_response_valid && empty));

endmodule

// File: tb/tb_rice_core_bus_arbiter.sv
// Randomised and directed bench for rice_core_bus_arbiter against a queue-based reference model.
module tb_rice_core_bus_arbiter;

  localparam int XLEN    = 32;
  localparam int MAX_OUT = 2;

  typedef struct packed {
    logic            iv;
    logic [XLEN-1:0] ia;
    logic            dv;
    logic [XLEN-1:0] da;
    logic [XLEN-1:0] dwd;
    logic            dw;
    logic [3:0]      ds;
    logic            mrdy;
    logic            rv;
    logic [XLEN-1:0] rdata;
    logic            rerr;
    logic            irr;
    logic            drr;
  } stim_t;

  logic              i_clk, i_rst_n;
  logic              i_inst_request_valid, o_inst_request_ready;
  logic [XLEN-1:0]   i_inst_address;
  logic              o_inst_response_valid, i_inst_response_ready;
  logic [XLEN-1:0]   o_inst_response_data;
  logic              o_inst_response_error;
  logic              i_data_request_valid, o_data_request_ready;
  logic [XLEN-1:0]   i_data_address, i_data_write_data;
  logic              i_data_write;
  logic [XLEN/8-1:0] i_data_strobe;
  logic              o_data_response_valid, i_data_response_ready;
  logic [XLEN-1:0]   o_data_response_data;
  logic              o_data_response_error;
  logic              o_mem_request_valid, i_mem_request_ready;
  logic [XLEN-1:0]   o_mem_address, o_mem_write_data;
  logic              o_mem_write;
  logic [XLEN/8-1:0] o_mem_strobe;
  logic              i_mem_response_valid, o_mem_response_ready;
  logic [XLEN-1:0]   i_mem_response_data;
  logic              i_mem_response_error;

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 = INST, 1 = DATA.
  bit src_q[$];
  bit last_g;
  bit locked;
  bit held;
  bit inst_hs, data_hs, last_pop;

  rice_core_bus_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_inst_request_valid(i_inst_request_valid), .o_inst_request_ready(o_inst_request_ready),
    .i_inst_address(i_inst_address),
    .o_inst_response_valid(o_inst_response_valid), .i_inst_response_ready(i_inst_response_ready),
    .o_inst_response_data(o_inst_response_data), .o_inst_response_error(o_inst_response_error),
    .i_data_request_valid(i_data_request_valid), .o_data_request_ready(o_data_request_ready),
    .i_data_address(i_data_address), .i_data_write_data(i_data_write_data),
    .i_data_write(i_data_write), .i_data_strobe(i_data_strobe),
    .o_data_response_valid(o_data_response_valid), .i_data_response_ready(i_data_response_ready),
    .o_data_response_data(o_data_response_data), .o_data_response_error(o_data_response_error),
    .o_mem_request_valid(o_mem_request_valid), .i_mem_request_ready(i_mem_request_ready),
    .o_mem_address(o_mem_address), .o_mem_write_data(o_mem_write_data),
    .o_mem_write(o_mem_write), .o_mem_strobe(o_mem_strobe),
    .i_mem_response_valid(i_mem_response_valid), .o_mem_response_ready(o_mem_response_ready),
    .i_mem_response_data(i_mem_response_data), .i_mem_response_error(i_mem_response_error)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    src_q.delete();
    last_g = 1'b1;
    locked = 1'b0;
    held   = 1'b0;
  endtask

  task automatic driveInputs(input stim_t s);
    i_inst_request_valid  = s.iv;
    i_inst_address        = s.ia;
    i_data_request_valid  = s.dv;
    i_data_address        = s.da;
    i_data_write_data     = s.dwd;
    i_data_write          = s.dw;
    i_data_strobe         = s.ds;
    i_mem_request_ready   = s.mrdy;
    i_mem_response_valid  = s.rv;
    i_mem_response_data   = s.rdata;
    i_mem_response_error  = s.rerr;
    i_inst_response_ready = s.irr;
    i_data_response_ready = s.drr;
  endtask

  // One clock: drive after the edge, check at the falling edge, then advance the model.
  task automatic applyStimulus(input stim_t s);
    bit full, empty, any, g, exp_mv, hs, head, exp_rr, exp_iv, exp_dv;
    @(posedge i_clk);
    #1;
    driveInputs(s);
    @(negedge i_clk);
    full  = (src_q.size() == MAX_OUT);
    empty = (src_q.size() == 0);
    any   = 1'b0;
    g     = 1'b0;
    if (locked) begin
      any = 1'b1;
      g   = held;
    end else if (!full && (s.iv || s.dv)) begin
      any = 1'b1;
      g   = (s.iv && s.dv) ? !last_g : s.dv;
    end
    exp_mv = any && !full && (g ? s.dv : s.iv);
    checkOutput("mem_req_valid", o_mem_request_valid, exp_mv);
    checkOutput("inst_req_ready", o_inst_request_ready, any && !g && s.mrdy && !full);
    checkOutput("data_req_ready", o_data_request_ready, any && g && s.mrdy && !full);
    if (exp_mv) begin
      checkOutput("mem_address", o_mem_address, g ? s.da : s.ia);
      checkOutput("mem_write", o_mem_write, g ? s.dw : 1'b0);
      checkOutput("mem_strobe", o_mem_strobe, g ? s.ds : 4'h0);
      if (g) checkOutput("mem_wdata", o_mem_write_data, s.dwd);
    end
    head   = empty ? 1'b0 : src_q[0];
    exp_rr = !empty && (head ? s.drr : s.irr);
    exp_iv = s.rv && !empty && !head;
    exp_dv = s.rv && !empty && head;
    checkOutput("mem_rsp_ready", o_mem_response_ready, exp_rr);
    checkOutput("inst_rsp_valid", o_inst_response_valid, exp_iv);
    checkOutput("data_rsp_valid", o_data_response_valid, exp_dv);
    if (exp_iv) begin
      checkOutput("inst_rsp_data", o_inst_response_data, s.rdata);
      checkOutput("inst_rsp_error", o_inst_response_error, s.rerr);
    end
    if (exp_dv) begin
      checkOutput("data_rsp_data", o_data_response_data, s.rdata);
      checkOutput("data_rsp_error", o_data_response_error, s.rerr);
    end
    hs       = exp_mv && s.mrdy;
    last_pop = s.rv && exp_rr;
    inst_hs  = hs && !g;
    data_hs  = hs && g;
    if (last_pop) void'(src_q.pop_front());
    if (hs) begin
      src_q.push_back(g);
      last_g = g;
    end
    locked = hs ? 1'b0 : (locked || (exp_mv && !s.mrdy));
    held   = g;
  endtask

  task automatic checkAllQuiet(input string tag);
    checkOutput({tag, "_mem_req_valid"}, o_mem_request_valid, 1'b0);
    checkOutput({tag, "_inst_req_ready"}, o_inst_request_ready, 1'b0);
    checkOutput({tag, "_data_req_ready"}, o_data_request_ready, 1'b0);
    checkOutput({tag, "_inst_rsp_valid"}, o_inst_response_valid, 1'b0);
    checkOutput({tag, "_data_rsp_valid"}, o_data_response_valid, 1'b0);
    checkOutput({tag, "_mem_rsp_ready"}, o_mem_response_ready, 1'b0);
  endtask

  initial begin
    stim_t s;
    stim_t hold_s;
    bit    inst_hold, data_hold, rsp_hold;

    s = '0;
    driveInputs(s);
    i_rst_n = 1'b0;
    modelReset();
    i_mem_request_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #2;
    checkAllQuiet("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Lone fetch, then its response one cycle later.
    s = '0; s.iv = 1; s.ia = 32'h0000_0100; s.mrdy = 1; s.irr = 1; s.drr = 1;
    applyStimulus(s);
    checkOutput("t1_inst_granted", o_inst_request_ready, 1'b1);
    s = '0; s.mrdy = 1; s.rv = 1; s.rdata = 32'hDEAD_BEEF; s.irr = 1; s.drr = 1;
    applyStimulus(s);
    checkOutput("t1_rsp_data", o_inst_response_data, 32'hDEAD_BEEF);
    checkOutput("t1_data_silent", o_data_response_valid, 1'b0);

    // Stalled store locks DATA while fetch waits.
    for (int k = 0; k < 4; k++) begin
      s = '0; s.iv = 1; s.ia = 32'h0000_0300; s.dv = 1; s.da = 32'h0000_2000;
      s.dwd = 32'h1234_5678; s.dw = 1; s.ds = 4'hF; s.mrdy = (k == 3); s.irr = 1; s.drr = 1;
      applyStimulus(s);
      checkOutput("t3_data_locked", o_mem_write, 1'b1);
    end
    s = '0; s.iv = 1; s.ia = 32'h0000_0300; s.mrdy = 1; s.irr = 1; s.drr = 1;
    applyStimulus(s);
    checkOutput("t3_inst_after", o_inst_request_ready, 1'b1);

    // Queue full: blocked even while a pop happens.
    s = '0; s.dv = 1; s.da = 32'h0000_4000; s.mrdy = 1; s.irr = 1; s.drr = 1;
    applyStimulus(s);
    checkOutput("t4_full_ready", o_data_request_ready, 1'b0);
    s.rv = 1; s.rdata = 32'h1111_0001;
    applyStimulus(s);
    checkOutput("t4_full_pop_valid", o_mem_request_valid, 1'b0);
    checkOutput("t5_r1_on_data", o_data_response_valid, 1'b1);
    s.rdata = 32'h2222_0002;
    applyStimulus(s);
    checkOutput("t4_grant_next", o_data_request_ready, 1'b1);
    checkOutput("t5_r2_on_inst", o_inst_response_valid, 1'b1);
    s = '0; s.rv = 1; s.rdata = 32'h3333_0003; s.irr = 1; s.drr = 0;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(s);
      checkOutput("t5_stall_ready", o_mem_response_ready, 1'b0);
    end
    s.drr = 1;
    applyStimulus(s);
    checkOutput("t5_release", o_mem_response_ready, 1'b1);

    // Two outstanding, then asynchronous reset mid-cycle.
    for (int k = 0; k < 2; k++) begin
      s = '0; s.iv = 1; s.ia = 32'h500 + k; s.dv = 1; s.da = 32'h600 + k; s.mrdy = 1;
      applyStimulus(s);
    end
    @(posedge i_clk);
    #1;
    s = '0; s.mrdy = 1; s.rv = 1; s.irr = 1; s.drr = 1;
    driveInputs(s);
    #1;
    checkOutput("pre_rst_rsp_ready", o_mem_response_ready, 1'b1);
    i_rst_n = 1'b0;
    #1;
    checkAllQuiet("async_rst");
    i_mem_response_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #3;
    i_rst_n = 1'b1;
    modelReset();

    // Alternation from reset with responses streaming back.
    for (int k = 0; k < 6; k++) begin
      s = '0; s.iv = 1; s.ia = 32'h700 + k; s.dv = 1; s.da = 32'h800 + k; s.mrdy = 1;
      s.rv = (src_q.size() > 0); s.rdata = $urandom; s.irr = 1; s.drr = 1;
      applyStimulus(s);
      checkOutput("alt_inst_grant", o_inst_request_ready, (k % 2) == 0);
    end

    // Random traffic obeying the hold-while-not-ready rules on both sides.
    inst_hold = 0; data_hold = 0; rsp_hold = 0; hold_s = s;
    for (int n = 0; n < 500; n++) begin
      s = hold_s;
      if (!inst_hold) begin
        s.iv = $urandom_range(0, 1); s.ia = $urandom;
      end
      if (!data_hold) begin
        s.dv = $urandom_range(0, 1); s.da = $urandom; s.dwd = $urandom;
        s.dw = $urandom_range(0, 1); s.ds = 4'($urandom);
      end
      if (!rsp_hold) begin
        s.rv = (src_q.size() > 0) && ($urandom_range(0, 1) == 1);
        s.rdata = $urandom; s.rerr = $urandom_range(0, 1);
      end
      s.mrdy = ($urandom_range(0, 3) != 0);
      s.irr  = ($urandom_range(0, 3) != 0);
      s.drr  = ($urandom_range(0, 3) != 0);
      applyStimulus(s);
      inst_hold = s.iv && !inst_hs;
      data_hold = s.dv && !data_hs;
      rsp_hold  = s.rv && !last_pop;
      hold_s    = s;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rice_core_bus_arbiter.md
# rice_core_bus_arbiter

Two-to-one bus arbiter between the core's instruction-fetch port and its load/store port and a single shared memory port. It grants one requester per cycle, round-robin with request locking, and keeps an ordered queue of grant sources so in-order responses return to the right requester. Request and response paths add zero cycles of latency.

## Interface
- XLEN, 32: address/data width.
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered requests; 1..4.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_inst_request_valid / o_inst_request_ready  in/out  1  fetch request handshake.
- i_inst_address  in  XLEN  fetch address.
- o_inst_response_valid / i_inst_response_ready  out/in  1  fetch response handshake.
- i_data_request_valid / o_data_request_ready  in/out  1  load/store request handshake.
- i_data_address, i_data_write_data  in  XLEN  load/store address and store data.
- i_data_write  in  1  1 = store.
- i_data_strobe  in  XLEN/8  store byte enables.
- o_data_response_valid / i_data_response_ready  out/in  1  load/store response handshake.
- o_mem_request_valid / i_mem_request_ready  out/in  1  shared-port request.
- o_mem_address, o_mem_write_data  out  XLEN  muxed from the granted source; inst forces write 0, strobe 0.
- o_mem_write, o_mem_strobe  out  1, XLEN/8.
- i_mem_response_valid / o_mem_response_ready  in/out  1  shared-port response.
- i_mem_response_data  in  XLEN, i_mem_response_error  in  1: fanned to both o_*_response_data/o_*_response_error (XLEN, 1). Only the routed side's valid is asserted.

## Operation
- Grant selection: when unlocked and the queue is not full, choose among valid requesters. If both are valid, choose the one not granted last. last_grant updates on each accepted request, i.e. a mem request handshake.
- Lock: if o_mem_request_valid && !i_mem_request_ready, set lock and hold the current grant until the handshake. A requester must hold valid and its payload stable while not ready. Lock clears on handshake.
- o_mem_request_valid = granted source valid && !full. o_<src>_request_ready = granted && i_mem_request_ready && !full. The non-granted side's ready is 0.
- Source queue: FIFO of 1-bit source IDs, depth MAX_OUTSTANDING. Push the granted ID on a mem request handshake. Pop on a mem response handshake.
- Response routing: head ID selects the destination. o_<head>_response_valid = i_mem_response_valid && !empty. o_mem_response_ready = i_<head>_response_ready && !empty.
- Empty queue with i_mem_response_valid: drop nothing, o_mem_response_ready = 0, flag via assertion (protocol error).
- Full queue: no grant, both request readys 0, o_mem_request_valid 0. A pop in the same cycle does not unblock; the grant is issued the next cycle.
- Push and pop in the same cycle when not full: count unchanged, both pointers advance.

## Timing
- Reset values: all readys and valids 0, lock 0, count 0, pointers 0, last_grant = DATA (so INST wins the first tie).
- Request path: combinational, 0-cycle latency from requester valid to o_mem_request_valid.
- Response path: combinational, 0-cycle latency.
- Responses must arrive no earlier than the cycle after their request handshake.
- Throughput: 1 request/cycle while the queue is not full.
- Asserting reset mid-transaction clears the queue and lock immediately. Responses arriving afterwards are treated as protocol errors; the memory side must be reset together with the arbiter.

## Structure
- rice_core_pkg: typedef enum logic {RICE_BUS_SOURCE_INST, RICE_BUS_SOURCE_DATA} rice_bus_source.
- Sub-module rice_core_bus_arbiter_source_fifo:
  - Parameterised depth, 1-bit payload of type rice_bus_source.
  - Outputs full, empty, head.
  - Count width $clog2(MAX_OUTSTANDING+1).
  - Pointer wrap at MAX_OUTSTANDING, which need not be a power of two.
- Top level holds grant/lock/last_grant registers and the muxes.

## Test plan
- Only inst valid, address 0x0000_0100, mem ready, response 0xDEAD_BEEF after 1 cycle -> inst granted the same cycle; o_inst_response_valid with data 0xDEAD_BEEF; data side silent.
- Both valid every cycle, mem always ready -> grants alternate INST, DATA, INST, DATA starting with INST after reset.
- Data store (0x2000, strobe 0xF) with i_mem_request_ready held 0 for 3 cycles while inst also valid -> grant stays DATA all 4 cycles; INST granted the cycle after the handshake.
- MAX_OUTSTANDING=2, two requests accepted, no responses -> third request sees ready 0 and o_mem_request_valid 0; first response pops; grant issued the next cycle.
- Accept INST then DATA; responses R1, R2 in order -> R1 only on inst, R2 only on data. Hold i_data_response_ready=0 for 2 cycles -> o_mem_response_ready=0 and R2 stalls.
- Reset asserted with 2 outstanding -> all outputs 0 asynchronously; after release, the first grant is INST.
